// File: rtl/dep_issue_scheduler_if.sv
// Handshake bundle between the instruction front-end, the dependency table and the issue port.
interface dep_issue_scheduler_if #(
  parameter int unsigned REGNUM = 32,
  parameter int unsigned BS     = 16
);
  localparam int unsigned RW = $clog2(REGNUM);
  localparam int unsigned IW = $clog2(BS);
  localparam int unsigned OW = $clog2(BS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic [RW-1:0] in_rd;
  logic [IW-1:0] in_index;

  logic          irt_we;
  logic [IW-1:0] irt_index;
  logic [RW-1:0] irt_rs1;
  logic [RW-1:0] irt_rs2;
  logic [RW-1:0] irt_rd;
  logic [BS-1:0] irt_idt;

  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic          issue_ready;

  logic          cmp_valid;
  logic [IW-1:0] cmp_index;

  logic [OW-1:0] occupancy;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, irt_idt, issue_ready, cmp_valid, cmp_index,
    input  in_ready, in_index, irt_we, irt_index, irt_rs1, irt_rs2, irt_rd,
           issue_valid, issue_index, occupancy
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, irt_idt, issue_ready, cmp_valid, cmp_index,
    output in_ready, in_index, irt_we, irt_index, irt_rs1, irt_rs2, irt_rd,
           issue_valid, issue_index, occupancy
  );
endinterface

// File: rtl/dep_issue_scheduler.sv
// Instruction-window controller: allocates slots, captures dependency vectors,
// issues ready entries in lowest-index order and retires them on completion.
module dep_issue_scheduler #(
  parameter int unsigned REGNUM = 32,
  parameter int unsigned BS     = 16
) (
  input logic                  clk,
  input logic                  rst,
  dep_issue_scheduler_if.slave bus
);
  localparam int unsigned RW = $clog2(REGNUM);
  localparam int unsigned IW = $clog2(BS);
  localparam int unsigned OW = $clog2(BS + 1);

  typedef enum logic [1:0] {FREE, PENDING, WAITING, ISSUED} slot_state_t;

  slot_state_t   state_q [BS];
  logic [BS-1:0] wait_q  [BS];
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  logic [OW-1:0] occ_q;

  logic [BS-1:0] free_vec;
  logic [BS-1:0] elig_vec;
  logic [BS-1:0] cmp_oh;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] elig_idx;
  logic          any_free;
  logic          any_elig;
  logic          alloc;
  logic          cmp_ok;
  logic          iss_valid;
  logic [IW-1:0] iss_idx;
  logic          iss_fire;

  // Slot classification and lowest-index pickers, all from registered state.
  always_comb begin
    free_vec = '0;
    elig_vec = '0;
    for (int i = 0; i < BS; i++) begin
      free_vec[i] = (state_q[i] == FREE);
      elig_vec[i] = (state_q[i] == WAITING) && (wait_q[i] == '0);
    end
    free_idx = '0;
    elig_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = IW'(i);
      if (elig_vec[i]) elig_idx = IW'(i);
    end
  end

  assign any_free  = |free_vec;
  assign any_elig  = |elig_vec;
  assign alloc     = bus.in_valid && any_free;
  // Completions for slots that are not ISSUED are ignored entirely.
  assign cmp_ok    = bus.cmp_valid && (state_q[bus.cmp_index] == ISSUED);
  assign cmp_oh    = cmp_ok ? (BS'(1) << bus.cmp_index) : '0;
  assign iss_valid = lock_q || any_elig;
  assign iss_idx   = lock_q ? lock_idx_q : elig_idx;
  assign iss_fire  = iss_valid && bus.issue_ready;

  assign bus.in_ready    = any_free;
  assign bus.in_index    = free_idx;
  assign bus.irt_we      = alloc;
  assign bus.irt_index   = alloc ? free_idx   : IW'(0);
  assign bus.irt_rs1     = alloc ? bus.in_rs1 : RW'(0);
  assign bus.irt_rs2     = alloc ? bus.in_rs2 : RW'(0);
  assign bus.irt_rd      = alloc ? bus.in_rd  : RW'(0);
  assign bus.issue_valid = iss_valid;
  assign bus.issue_index = iss_idx;
  assign bus.occupancy   = occ_q;

  // Per-slot lifecycle; at most one slot is PENDING, the one allocated last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= FREE;
        wait_q[i]  <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      occ_q      <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        case (state_q[i])
          FREE: begin
            if (alloc && (free_idx == IW'(i))) state_q[i] <= PENDING;
          end
          PENDING: begin
            // Mask freed-slot columns, the completing slot and self out of the table vector.
            state_q[i] <= WAITING;
            wait_q[i]  <= bus.irt_idt & ~free_vec & ~cmp_oh & ~(BS'(1) << i);
          end
          WAITING: begin
            wait_q[i] <= wait_q[i] & ~cmp_oh;
            if (iss_fire && (iss_idx == IW'(i))) state_q[i] <= ISSUED;
          end
          ISSUED: begin
            if (cmp_ok && (bus.cmp_index == IW'(i))) state_q[i] <= FREE;
          end
          default: state_q[i] <= FREE;
        endcase
      end
      // A stalled offer is locked so the issue index cannot change under the consumer.
      lock_q     <= iss_valid && !bus.issue_ready;
      lock_idx_q <= iss_idx;
      occ_q      <= occ_q + OW'(alloc) - OW'(cmp_ok);
    end
  end
endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Scoreboard bench for dep_issue_scheduler: directed scenarios push expected table
// writes and issues; a negedge monitor pops and compares them as the DUT produces them.
module tb_dep_issue_scheduler;
  localparam int unsigned REGNUM = 32;
  localparam int unsigned BS     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dep_issue_scheduler_if #(.REGNUM(REGNUM), .BS(BS)) bus ();

  dep_issue_scheduler #(.REGNUM(REGNUM), .BS(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [18:0] alloc_q [$];
  logic [35:0] issue_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every table write and every issue handshake must match the head of its queue.
  always @(negedge clk) begin
    logic [18:0] a;
    logic [35:0] s;
    if (!rst) begin
      if (bus.irt_we) begin
        if (alloc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL alloc_unexpected: got irt_index %0d expected no write (cycle %0d)",
                   bus.irt_index, cyc);
        end else begin
          a = alloc_q.pop_front();
          chk("alloc_write", 32'({bus.irt_index, bus.irt_rs1, bus.irt_rs2, bus.irt_rd}), 32'(a));
        end
      end
      if (bus.issue_valid && bus.issue_ready) begin
        if (issue_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: got index %0d expected no issue (cycle %0d)",
                   bus.issue_index, cyc);
        end else begin
          s = issue_q.pop_front();
          chk("issue_index", 32'(bus.issue_index), 32'(s[35:32]));
          chk("issue_cycle", cyc, s[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.cmp_valid = 1'b0;
    bus.cmp_index = '0;
    bus.irt_idt   = '0;
  endtask

  task automatic alloc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] idx);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    alloc_q.push_back({idx, rs1, rs2, rd});
  endtask

  task automatic exp_issue(input logic [3:0] idx, input int unsigned at);
    issue_q.push_back({idx, 32'(at)});
  endtask

  task automatic cmp(input logic [3:0] idx);
    bus.cmp_valid = 1'b1;
    bus.cmp_index = idx;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},    32'(bus.in_ready),    32'd1);
    chk({tag, "_in_index"},    32'(bus.in_index),    32'd0);
    chk({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'd0);
    chk({tag, "_occupancy"},   32'(bus.occupancy),   32'd0);
    chk({tag, "_irt_we"},      32'(bus.irt_we),      32'd0);
  endtask

  initial begin
    int unsigned c;
    bus.in_valid    = 1'b0;
    bus.in_rs1      = '0;
    bus.in_rs2      = '0;
    bus.in_rd       = '0;
    bus.irt_idt     = '0;
    bus.issue_ready = 1'b1;
    bus.cmp_valid   = 1'b0;
    bus.cmp_index   = '0;

    // Reset then idle.
    chk_reset_outputs("rst_hold");
    tick(); rst = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Two independent entries issue back to back.
    tick(); c = cyc; alloc(5'd1, 5'd2, 5'd3, 4'd0); exp_issue(4'd0, c + 2);
    tick(); alloc(5'd4, 5'd5, 5'd6, 4'd1); exp_issue(4'd1, c + 3);
    tick();
    tick();
    tick(); @(negedge clk); chk("two_occ", 32'(bus.occupancy), 32'd2);
    cmp(4'd0);
    tick(); cmp(4'd1);
    tick(); @(negedge clk); chk("two_drain_occ", 32'(bus.occupancy), 32'd0);

    // Slot 1 depends on slot 0 and wakes on its completion.
    tick(); c = cyc; alloc(5'd0, 5'd0, 5'd5, 4'd0); exp_issue(4'd0, c + 2);
    tick(); alloc(5'd5, 5'd0, 5'd6, 4'd1);
    tick(); bus.irt_idt = 16'h0001;
    tick(); @(negedge clk); chk("dep_blocked", 32'(bus.issue_valid), 32'd0);
    tick(); cmp(4'd0); exp_issue(4'd1, c + 5);
    tick(); @(negedge clk); chk("dep_occ", 32'(bus.occupancy), 32'd1);
    tick(); cmp(4'd1);
    tick();

    // Fill the window; extra offers are held off; a freed slot reappears a cycle later.
    tick(); c = cyc;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      alloc(5'(i), 5'(i + 1), 5'(i + 2), 4'(i));
      exp_issue(4'(i), c + 32'(i) + 2);
    end
    tick(); bus.in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_irt_we",   32'(bus.irt_we),   32'd0);
    chk("full_occ",      32'(bus.occupancy), 32'd16);
    tick(); bus.in_valid = 1'b1;
    tick();
    tick(); cmp(4'd7);
    @(negedge clk); chk("free_same_cycle", 32'(bus.in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("free_next_ready", 32'(bus.in_ready), 32'd1);
    chk("free_next_index", 32'(bus.in_index), 32'd7);
    for (int i = 0; i < 16; i++) begin
      if (i != 7) begin
        tick(); cmp(4'(i));
      end
    end
    tick(); @(negedge clk); chk("fill_drain_occ", 32'(bus.occupancy), 32'd0);

    // Completion during capture masks the dependency; all-ones vector keeps only live slots.
    tick(); c = cyc; alloc(5'd1, 5'd1, 5'd1, 4'd0); exp_issue(4'd0, c + 2);
    tick(); alloc(5'd2, 5'd2, 5'd2, 4'd1); exp_issue(4'd1, c + 3);
    tick(); alloc(5'd3, 5'd3, 5'd3, 4'd2); exp_issue(4'd2, c + 4);
    tick();
    tick(); alloc(5'd4, 5'd4, 5'd4, 4'd3); exp_issue(4'd3, c + 6);
    tick(); bus.irt_idt = 16'h0004; cmp(4'd2);
    tick(); @(negedge clk); chk("cap_cmp_occ", 32'(bus.occupancy), 32'd3);
    tick(); cmp(4'd1);
    tick(); cmp(4'd3);
    tick(); alloc(5'd9, 5'd8, 5'd7, 4'd1);
    tick(); bus.irt_idt = 16'hFFFF;
    tick(); @(negedge clk); chk("ones_blocked_a", 32'(bus.issue_valid), 32'd0);
    tick(); @(negedge clk); chk("ones_blocked_b", 32'(bus.issue_valid), 32'd0);
    cmp(4'd0); exp_issue(4'd1, c + 13);
    tick();
    tick(); cmp(4'd1);
    tick(); @(negedge clk); chk("ones_drain_occ", 32'(bus.occupancy), 32'd0);

    // Stalled issue of slot 4 stays locked while slot 1 becomes eligible.
    tick(); c = cyc; alloc(5'd0, 5'd0, 5'd10, 4'd0); exp_issue(4'd0, c + 2);
    tick(); alloc(5'd10, 5'd0, 5'd11, 4'd1);
    tick(); alloc(5'd10, 5'd0, 5'd12, 4'd2); bus.irt_idt = 16'h0001;
    tick(); bus.issue_ready = 1'b0; alloc(5'd10, 5'd0, 5'd13, 4'd3); bus.irt_idt = 16'h0001;
    tick(); alloc(5'd1, 5'd2, 5'd14, 4'd4); bus.irt_idt = 16'h0001;
    tick();
    tick(); @(negedge clk);
    chk("lock_valid", 32'(bus.issue_valid), 32'd1);
    chk("lock_index", 32'(bus.issue_index), 32'd4);
    tick(); cmp(4'd0);
    @(negedge clk); chk("lock_index_cmp", 32'(bus.issue_index), 32'd4);
    tick(); cmp(4'd2);
    @(negedge clk);
    chk("lock_hold_valid", 32'(bus.issue_valid), 32'd1);
    chk("lock_hold_index", 32'(bus.issue_index), 32'd4);
    tick(); bus.issue_ready = 1'b1;
    exp_issue(4'd4, c + 9); exp_issue(4'd1, c + 10);
    exp_issue(4'd2, c + 11); exp_issue(4'd3, c + 12);
    @(negedge clk); chk("ignored_cmp_occ", 32'(bus.occupancy), 32'd4);
    tick();
    tick();
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick(); cmp(4'(i));
    end
    tick(); @(negedge clk); chk("lock_drain_occ", 32'(bus.occupancy), 32'd0);

    // Reset with three entries in flight.
    tick(); c = cyc; alloc(5'd1, 5'd0, 5'd2, 4'd0); exp_issue(4'd0, c + 2);
    tick(); alloc(5'd3, 5'd0, 5'd4, 4'd1); exp_issue(4'd1, c + 3);
    tick(); alloc(5'd5, 5'd0, 5'd6, 4'd2); exp_issue(4'd2, c + 4);
    tick();
    tick();
    tick(); @(negedge clk); chk("pre_rst_occ", 32'(bus.occupancy), 32'd3);
    rst = 1'b1;
    chk_reset_outputs("mid_rst");
    tick(); rst = 1'b0;
    tick(); c = cyc; alloc(5'd7, 5'd7, 5'd7, 4'd0); exp_issue(4'd0, c + 2);
    tick();
    tick();
    tick(); @(negedge clk); chk("post_rst_occ", 32'(bus.occupancy), 32'd1);

    tick();
    tick();
    chk("alloc_q_empty", 32'(alloc_q.size()), 32'd0);
    chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
